key_event_bank: RTL and testbench

Parametrised successor to the per-key filter bank in the vending top level. It replaces N separate single-edge debouncers with one N-channel block. Each channel provides a 2-FF synchronizer, a debouncer, press and release edges, long-press detection and optional auto-repeat. All events are merged into one buffered, arbitrated event stream that the vending state machine consumes with a valid/ready handshake.

---
 rtl/key_event_bank.sv | 258 +++++++++++++++++++++++++
 tb/tb_key_event_bank.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_bank.sv
// key_event_bank: N-channel key front end. Each channel synchronizes, debounces and
// times its key, producing press/release/long/repeat pulses. The pulses are collected
// in per-key pending flags, arbitrated one per cycle into a show-ahead event FIFO and
// handed to the consumer with a valid/ready handshake.
module key_event_bank #(
    parameter int unsigned N_KEYS        = 16,
    parameter logic        PRESS_LEVEL   = 1'b1,
    parameter int unsigned DEB_CYCLES    = 2000000,
    parameter int unsigned LONG_CYCLES   = 100000000,
    parameter int unsigned REPEAT_CYCLES = 20000000,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned CODE_W        = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_posedge,
    output logic [N_KEYS-1:0] key_negedge,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              evt_valid,
    output logic [CODE_W-1:0] evt_code,
    output logic [1:0]        evt_type,
    input  logic              evt_ready,
    output logic              evt_overflow,
    input  logic              ovf_clr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = CODE_W + 2;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // Event type codes double as the bit index into each key's pending vector.
    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    // Within one key: press > long > repeat > release.
    function automatic logic [1:0] pick_type(input logic [3:0] p);
        if (p[EVT_PRESS]) begin
            return EVT_PRESS;
        end else if (p[EVT_LONG]) begin
            return EVT_LONG;
        end else if (p[EVT_REPEAT]) begin
            return EVT_REPEAT;
        end
        return EVT_RELEASE;
    endfunction

    logic [3:0] evt_pulse [N_KEYS];

    // ------------------------------------------------------------------
    // Per-key channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic             key_norm;
        logic [1:0]       sync_q, sync_d;
        logic             stable_q, stable_d;
        logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
        logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
        logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             pos_q, pos_d;
        logic             neg_q, neg_d;
        logic             long_q, long_d;
        logic             rep_q, rep_d;
        logic             accept;

        // 1 means pressed regardless of the board's key polarity.
        assign key_norm = key_in[i] ~^ PRESS_LEVEL;

        // Debounce, edge detection and hold/repeat timing for one key.
        always_comb begin
            sync_d     = {sync_q[0], key_norm};
            stable_d   = stable_q;
            deb_cnt_d  = '0;
            accept     = 1'b0;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            long_d     = 1'b0;
            rep_d      = 1'b0;

            if (sync_q[1] != stable_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    accept   = 1'b1;
                    stable_d = sync_q[1];
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            // Edge pulses are registered so they line up with the new key_level.
            pos_d = accept & sync_q[1];
            neg_d = accept & ~sync_q[1];

            if (accept) begin
                // Both press and release restart the hold timing; a release
                // edge also blocks any long/repeat pulse in the same cycle.
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end else if (stable_q) begin
                if (hold_cnt_q != LONG_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    long_d     = (hold_cnt_q == LONG_LAST);
                end else if (repeat_en[i]) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = '0;
                        rep_d     = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_q     <= '0;
                stable_q   <= 1'b0;
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                pos_q      <= 1'b0;
                neg_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                sync_q     <= sync_d;
                stable_q   <= stable_d;
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                pos_q      <= pos_d;
                neg_q      <= neg_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        assign key_level[i]   = stable_q;
        assign key_posedge[i] = pos_q;
        assign key_negedge[i] = neg_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = rep_q;
        assign evt_pulse[i]   = {rep_q, long_q, neg_q, pos_q};
    end

    // ------------------------------------------------------------------
    // Pending flags, arbiter and FIFO
    // ------------------------------------------------------------------
    logic [3:0]        pend_q [N_KEYS];
    logic [3:0]        pend_d [N_KEYS];
    logic [3:0]        clr_mask [N_KEYS];
    logic              grant_valid;
    logic [CODE_W-1:0] grant_key;
    logic [1:0]        grant_type;
    logic [3:0]        grant_onehot;
    logic              push, pop, fifo_full;
    logic              ovf_set;
    logic              ovf_q, ovf_d;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign fifo_full = (count_q == FIFO_FULL);
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    // A full FIFO still accepts a push in a cycle where the head leaves.
    assign push      = grant_valid & (~fifo_full | pop);

    // Fixed-priority arbiter: lowest key index with anything pending wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_key   = '0;
        grant_type  = EVT_PRESS;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (|pend_q[k]) begin
                grant_valid = 1'b1;
                grant_key   = CODE_W'(k);
                grant_type  = pick_type(pend_q[k]);
            end
        end
        grant_onehot = 4'b0001 << grant_type;
    end

    // Pending update; a pulse landing on a still-pending bit is merged and lost.
    always_comb begin
        ovf_set = 1'b0;
        for (int k = 0; k < N_KEYS; k++) begin
            clr_mask[k] = (push && (grant_key == CODE_W'(k))) ? grant_onehot : 4'b0000;
            pend_d[k]   = (pend_q[k] & ~clr_mask[k]) | evt_pulse[k];
            if (|(evt_pulse[k] & pend_q[k] & ~clr_mask[k])) begin
                ovf_set = 1'b1;
            end
        end
        // Set wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    // FIFO write, pointer and occupancy next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {grant_key, grant_type};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Shared event-path registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < N_KEYS; k++) begin
                pend_q[k] <= '0;
            end
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign {evt_code, evt_type} = mem_q[rd_ptr_q];
    assign evt_overflow         = ovf_q;

endmodule

// File: tb/tb_key_event_bank.sv
// Self-checking bench for key_event_bank: per-key pulse timing checked inline,
// event stream checked against a scoreboard queue of expected {code, type}.
module tb_key_event_bank;

    localparam int unsigned NK = 4;
    localparam int unsigned CW = 4;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_level, key_posedge, key_negedge, key_long, key_repeat;
    logic          evt_valid;
    logic [CW-1:0] evt_code;
    logic [1:0]    evt_type;
    logic          evt_ready;
    logic          evt_overflow;
    logic          ovf_clr;

    key_event_bank #(
        .N_KEYS        (NK),
        .PRESS_LEVEL   (1'b1),
        .DEB_CYCLES    (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (8),
        .FIFO_DEPTH    (4),
        .CNT_W         (8),
        .CODE_W        (CW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .repeat_en    (repeat_en),
        .key_level    (key_level),
        .key_posedge  (key_posedge),
        .key_negedge  (key_negedge),
        .key_long     (key_long),
        .key_repeat   (key_repeat),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_type     (evt_type),
        .evt_ready    (evt_ready),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [5:0] exp_q [$];
    int         pop_cyc_q [$];
    logic [5:0] got_ev, want_ev;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event monitor: every handshake pops one expected entry.
    always @(negedge sys_clk) begin
        if (sys_rst_n && evt_valid && evt_ready) begin
            got_ev = {evt_code, evt_type};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got code %0d type %b, required no event",
                         evt_code, evt_type);
            end else begin
                want_ev = exp_q.pop_front();
                if (got_ev !== want_ev) begin
                    errors++;
                    $display("FAIL evt_order: got code %0d type %b, required code %0d type %b",
                             got_ev[5:2], got_ev[1:0], want_ev[5:2], want_ev[1:0]);
                end
            end
            pop_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push_exp(input int key, input logic [1:0] typ);
        exp_q.push_back({CW'(key), typ});
    endtask

    task automatic wait_drain(input string name, input int bound);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            tick(1);
            c++;
        end
        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: evt_valid %b, required 0", name, evt_valid);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in    = '0;
        repeat_en = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick(3);
        checks++;
        if ({key_level, key_posedge, key_negedge, key_long, key_repeat} !== '0) begin
            errors++;
            $display("FAIL reset_keys: got %h, required 0",
                     {key_level, key_posedge, key_negedge, key_long, key_repeat});
        end
        checks++;
        if ({evt_valid, evt_code, evt_type, evt_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_evt: valid %b code %0d type %b ovf %b, required all 0",
                     evt_valid, evt_code, evt_type, evt_overflow);
        end
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_debounce();
        int bad, pos_at, pos_n;
        bad = 0;
        // 3-cycle glitch: one cycle short of acceptance.
        key_in[1] = 1'b1;
        tick(3);
        key_in[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (key_level[1] || key_posedge[1]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL deb_glitch: key 1 changed in %0d cycles, required 0", bad);
        end
        key_in[1] = 1'b1;
        push_exp(1, 2'b00);
        pos_at = -1;
        pos_n  = 0;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (key_posedge[1]) begin
                pos_n++;
                if (pos_at < 0) pos_at = c;
                if (key_level[1] !== 1'b1) bad++;
            end
        end
        checks++;
        if (pos_at != 6 || pos_n != 1 || bad != 0) begin
            errors++;
            $display("FAIL deb_press: posedge at %0d count %0d level-bad %0d, required 6/1/0",
                     pos_at, pos_n, bad);
        end
        key_in[1] = 1'b0;
        push_exp(1, 2'b01);
        pos_at = -1;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (key_negedge[1] && pos_at < 0) pos_at = c;
        end
        checks++;
        if (pos_at != 6) begin
            errors++;
            $display("FAIL deb_release: negedge at %0d, required 6", pos_at);
        end
        wait_drain("debounce", 20);
    endtask

    task automatic test_long_repeat();
        int long_at [$];
        int rep_at [$];
        int neg_at, found;
        int rep_exp [4];
        rep_exp = '{28, 36, 44, 52};
        repeat_en[2] = 1'b1;
        key_in[2]    = 1'b1;
        push_exp(2, 2'b00);
        push_exp(2, 2'b10);
        for (int r = 0; r < 4; r++) push_exp(2, 2'b11);
        found = 0;
        for (int c = 0; c < 12 && found == 0; c++) begin
            tick(1);
            if (key_posedge[2]) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL lr_press: no posedge on key 2, required one within 12 cycles");
        end
        neg_at = -1;
        for (int c = 1; c <= 70; c++) begin
            tick(1);
            if (key_long[2]) long_at.push_back(c);
            if (key_repeat[2]) rep_at.push_back(c);
            if (key_negedge[2] && neg_at < 0) neg_at = c;
            if (c == 54) begin
                key_in[2] = 1'b0;
                push_exp(2, 2'b01);
            end
        end
        checks++;
        if (long_at.size() != 1 || long_at[0] != 20) begin
            errors++;
            $display("FAIL lr_long: %0d pulses first at %0d, required 1 at 20",
                     long_at.size(), (long_at.size() > 0) ? long_at[0] : -1);
        end
        checks++;
        if (rep_at.size() != 4) begin
            errors++;
            $display("FAIL lr_repeat_count: got %0d repeat pulses, required 4", rep_at.size());
        end
        for (int r = 0; r < 4 && r < rep_at.size(); r++) begin
            checks++;
            if (rep_at[r] != rep_exp[r]) begin
                errors++;
                $display("FAIL lr_repeat_time: repeat %0d at %0d, required %0d",
                         r, rep_at[r], rep_exp[r]);
            end
        end
        checks++;
        if (neg_at != 60) begin
            errors++;
            $display("FAIL lr_release: negedge at %0d, required 60", neg_at);
        end
        repeat_en[2] = 1'b0;
        wait_drain("long_repeat", 20);
    endtask

    task automatic test_same_cycle();
        pop_cyc_q.delete();
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        push_exp(0, 2'b00);
        push_exp(3, 2'b00);
        tick(14);
        checks++;
        if (pop_cyc_q.size() != 2 || pop_cyc_q[1] - pop_cyc_q[0] != 1) begin
            errors++;
            $display("FAIL same_press: %0d pops, gap %0d, required 2 pops gap 1",
                     pop_cyc_q.size(),
                     (pop_cyc_q.size() == 2) ? pop_cyc_q[1] - pop_cyc_q[0] : -1);
        end
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        push_exp(0, 2'b01);
        push_exp(3, 2'b01);
        wait_drain("same_cycle", 20);
        checks++;
        if (pop_cyc_q.size() != 4 || pop_cyc_q[3] - pop_cyc_q[2] != 1) begin
            errors++;
            $display("FAIL same_release: %0d pops total, required 4 with last gap 1",
                     pop_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        key_in[2:0] = 3'b111;
        for (int k = 0; k < 3; k++) push_exp(k, 2'b00);
        tick(10);
        key_in[2:0] = 3'b000;
        for (int k = 0; k < 3; k++) push_exp(k, 2'b01);
        tick(14);
        checks++;
        if (evt_valid !== 1'b1 || {evt_code, evt_type} !== 6'b0000_00) begin
            errors++;
            $display("FAIL bp_head: valid %b code %0d type %b, required 1/0/00",
                     evt_valid, evt_code, evt_type);
        end
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_overflow: evt_overflow %b, required 0", evt_overflow);
        end
        checks++;
        if (exp_q.size() != 6) begin
            errors++;
            $display("FAIL bp_hold: %0d events consumed early, required 0", 6 - exp_q.size());
        end
        evt_ready = 1'b1;
        wait_drain("backpressure", 20);
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        key_in[2:1] = 2'b11;
        push_exp(1, 2'b00);
        push_exp(2, 2'b00);
        tick(10);
        key_in[2:1] = 2'b00;
        push_exp(1, 2'b01);
        push_exp(2, 2'b01);
        tick(12);
        // FIFO now full; key 0 events land in pending.
        key_in[0] = 1'b1;
        push_exp(0, 2'b00);
        tick(10);
        key_in[0] = 1'b0;
        push_exp(0, 2'b01);
        tick(12);
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: evt_overflow %b after first press/release, required 0",
                     evt_overflow);
        end
        key_in[0] = 1'b1;
        tick(10);
        key_in[0] = 1'b0;
        tick(12);
        checks++;
        if (evt_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: evt_overflow %b, required 1", evt_overflow);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (evt_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: evt_overflow %b, required 0", evt_overflow);
        end
        evt_ready = 1'b1;
        wait_drain("overflow", 20);
    endtask

    task automatic test_reset_mid_hold();
        int pos_at, long_at, found;
        key_in[2] = 1'b1;
        push_exp(2, 2'b00);
        found = 0;
        for (int c = 0; c < 12 && found == 0; c++) begin
            tick(1);
            if (key_posedge[2]) found = 1;
        end
        tick(10);
        checks++;
        if (found == 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_pre: posedge seen %0d, outstanding %0d, required 1/0",
                     found, exp_q.size());
            exp_q.delete();
        end
        sys_rst_n = 1'b0;
        #2;
        checks++;
        if ({key_level, key_posedge, key_negedge, key_long, key_repeat} !== '0 ||
            evt_valid !== 1'b0 || evt_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: level %b valid %b ovf %b, required all 0",
                     key_level, evt_valid, evt_overflow);
        end
        tick(3);
        sys_rst_n = 1'b1;
        push_exp(2, 2'b00);
        push_exp(2, 2'b10);
        pos_at  = -1;
        long_at = -1;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (key_posedge[2] && pos_at < 0) pos_at = c;
            if (key_long[2] && long_at < 0) long_at = c;
        end
        checks++;
        if (pos_at != 6) begin
            errors++;
            $display("FAIL rst_press: posedge at %0d after reset, required 6", pos_at);
        end
        checks++;
        if (long_at != 26) begin
            errors++;
            $display("FAIL rst_long: long at %0d after reset, required 26", long_at);
        end
        key_in[2] = 1'b0;
        push_exp(2, 2'b01);
        wait_drain("reset_mid_hold", 20);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_long_repeat();
        test_same_cycle();
        test_back_to_back();
        test_overflow();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
